// File: rtl/sdram_arbit_pkg.sv
// Shared types and constants for the SDRAM command arbiter.
package sdram_arbit_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StArbit = 3'd1,
    StAref  = 3'd2,
    StWrite = 3'd3,
    StRead  = 3'd4
  } state_e;

  // Channel the selector wants to grant next
  typedef enum logic [1:0] {
    ChNone  = 2'd0,
    ChAref  = 2'd1,
    ChWrite = 2'd2,
    ChRead  = 2'd3
  } chan_e;

  // Idle bus value: {CS#,RAS#,CAS#,WE#} = NOP, all-ones bank/address
  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [1:0]  NOP_BANK = 2'b11;
  localparam logic [12:0] NOP_ADDR = 13'h1fff;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
  } bus_t;

  function automatic bus_t nop_bus();
    bus_t b;
    b.cmd  = CMD_NOP;
    b.ba   = NOP_BANK;
    b.addr = NOP_ADDR;
    return b;
  endfunction

endpackage

// File: rtl/sdram_arbit_sel.sv
// Next-grant selector: refresh beats everything, then write/read.
// With SDRAM_ARB_RR_EN defined, write/read ties alternate using a last_rw
// flop; otherwise write always beats read.
module sdram_arbit_sel
  import sdram_arbit_pkg::*;
(
  input  logic  arb_clk,
  input  logic  arb_rst,
  input  logic  arbit,
  input  logic  aref_req,
  input  logic  wr_req,
  input  logic  rd_req,
  output chan_e next_ch
);

  logic wr_wins;

`ifdef SDRAM_ARB_RR_EN
  // 1 = write was served last, 0 = read (reset value, so write wins the first tie)
  logic last_rw_q;

  // Write wins unless a read is also pending and write was served last
  always_comb begin
    wr_wins = wr_req & (~rd_req | ~last_rw_q);
  end

  // Remember which of write/read the FSM is about to grant
  always_ff @(posedge arb_clk) begin
    if (arb_rst) begin
      last_rw_q <= 1'b0;
    end else if (arbit && (next_ch == ChWrite)) begin
      last_rw_q <= 1'b1;
    end else if (arbit && (next_ch == ChRead)) begin
      last_rw_q <= 1'b0;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{arb_clk, arb_rst, arbit};

  // Fixed priority: write over read
  always_comb begin
    wr_wins = wr_req;
  end
`endif

  // Priority decode of the pending requests
  always_comb begin
    next_ch = ChNone;
    if (aref_req) begin
      next_ch = ChAref;
    end else if (wr_wins) begin
      next_ch = ChWrite;
    end else if (rd_req) begin
      next_ch = ChRead;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants one sequencer at a time (init, then refresh,
// write or read) and drives the granted channel onto the pins through one
// register stage so command and data stay aligned.
// Optional feature macro: SDRAM_ARB_RR_EN (round-robin write/read tie-break).
module sdram_arbit
  import sdram_arbit_pkg::*;
(
  input  logic        arb_clk,
  input  logic        arb_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_bank,
  input  logic [12:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_bank,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_bank,
  input  logic [12:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_bank,
  input  logic [12:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  state_e      state_q;
  chan_e       next_ch;
  bus_t        sel_bus;
  bus_t        bus_q;
  logic        sel_oe;
  logic [15:0] sel_dq;
  logic [15:0] dq_q;
  logic        oe_q;

  sdram_arbit_sel u_sel (
    .arb_clk  (arb_clk),
    .arb_rst  (arb_rst),
    .arbit    (state_q == StArbit),
    .aref_req (aref_req),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .next_ch  (next_ch)
  );

  // Arbiter FSM; a grant is only released through ARBIT, so there is no preemption
  always_ff @(posedge arb_clk) begin
    if (arb_rst) begin
      state_q <= StInit;
    end else begin
      case (state_q)
        StInit:  if (init_end) state_q <= StArbit;
        StArbit: begin
          case (next_ch)
            ChAref:  state_q <= StAref;
            ChWrite: state_q <= StWrite;
            ChRead:  state_q <= StRead;
            default: state_q <= StArbit;
          endcase
        end
        StAref:  if (aref_end) state_q <= StArbit;
        StWrite: if (wr_end) state_q <= StArbit;
        StRead:  if (rd_end) state_q <= StArbit;
        default: state_q <= StInit;
      endcase
    end
  end

  // Grants decode the state; reset masks them immediately, ahead of the edge
  assign aref_en = (state_q == StAref)  & ~arb_rst;
  assign wr_en   = (state_q == StWrite) & ~arb_rst;
  assign rd_en   = (state_q == StRead)  & ~arb_rst;

  // Channel mux: ARBIT (and any illegal state) drives NOP
  always_comb begin
    sel_bus = nop_bus();
    case (state_q)
      StInit:  begin
        sel_bus.cmd  = init_cmd;
        sel_bus.ba   = init_bank;
        sel_bus.addr = init_addr;
      end
      StAref:  begin
        sel_bus.cmd  = aref_cmd;
        sel_bus.ba   = aref_bank;
        sel_bus.addr = aref_addr;
      end
      StWrite: begin
        sel_bus.cmd  = wr_cmd;
        sel_bus.ba   = wr_bank;
        sel_bus.addr = wr_addr;
      end
      StRead:  begin
        sel_bus.cmd  = rd_cmd;
        sel_bus.ba   = rd_bank;
        sel_bus.addr = rd_addr;
      end
      default: sel_bus = nop_bus();
    endcase
  end

  // Write data only drives the bus while the write sequencer holds the grant
  always_comb begin
    sel_oe = wr_sdram_en & (state_q == StWrite);
    sel_dq = sel_oe ? wr_sdram_data : 16'h0000;
  end

  // Single output register stage shared by command and data
  always_ff @(posedge arb_clk) begin
    if (arb_rst) begin
      bus_q <= nop_bus();
      dq_q  <= 16'h0000;
      oe_q  <= 1'b0;
    end else begin
      bus_q <= sel_bus;
      dq_q  <= sel_dq;
      oe_q  <= sel_oe;
    end
  end

  assign sdram_cke    = 1'b1;
  assign sdram_cs_n   = bus_q.cmd[3];
  assign sdram_ras_n  = bus_q.cmd[2];
  assign sdram_cas_n  = bus_q.cmd[1];
  assign sdram_we_n   = bus_q.cmd[0];
  assign sdram_ba     = bus_q.ba;
  assign sdram_addr   = bus_q.addr;
  assign sdram_dq_out = dq_q;
  assign sdram_dq_oe  = oe_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: an ownership model predicts grants
// and pins every cycle; directed steps add hand-computed literal checks.
module tb_sdram_arbit;

  logic        arb_clk = 1'b0;
  logic        arb_rst = 1'b1;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0111;
  logic [1:0]  init_bank = 2'b11;
  logic [12:0] init_addr = 13'h1fff;
  logic        aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'b0001;
  logic [1:0]  aref_bank = 2'b00;
  logic [12:0] aref_addr = 13'h0000;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [1:0]  wr_bank = 2'b01;
  logic [12:0] wr_addr = 13'h0040;
  logic        wr_sdram_en = 1'b0;
  logic [15:0] wr_sdram_data = 16'h0000;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [1:0]  rd_bank = 2'b10;
  logic [12:0] rd_addr = 13'h0080;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  sdram_arbit dut (
    .arb_clk       (arb_clk),
    .arb_rst       (arb_rst),
    .init_end      (init_end),
    .init_cmd      (init_cmd),
    .init_bank     (init_bank),
    .init_addr     (init_addr),
    .aref_req      (aref_req),
    .aref_end      (aref_end),
    .aref_cmd      (aref_cmd),
    .aref_bank     (aref_bank),
    .aref_addr     (aref_addr),
    .wr_req        (wr_req),
    .wr_end        (wr_end),
    .wr_cmd        (wr_cmd),
    .wr_bank       (wr_bank),
    .wr_addr       (wr_addr),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data),
    .rd_req        (rd_req),
    .rd_end        (rd_end),
    .rd_cmd        (rd_cmd),
    .rd_bank       (rd_bank),
    .rd_addr       (rd_addr),
    .aref_en       (aref_en),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .sdram_cke     (sdram_cke),
    .sdram_cs_n    (sdram_cs_n),
    .sdram_ras_n   (sdram_ras_n),
    .sdram_cas_n   (sdram_cas_n),
    .sdram_we_n    (sdram_we_n),
    .sdram_ba      (sdram_ba),
    .sdram_addr    (sdram_addr),
    .sdram_dq_out  (sdram_dq_out),
    .sdram_dq_oe   (sdram_dq_oe)
  );

  always #5 arb_clk = ~arb_clk;

  // Observed bundles: pins = {pad, cmd, ba, addr, oe, cke}
  logic [31:0] pins_v, grants_v, dq_v;
  assign pins_v   = {11'b0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                     sdram_ba, sdram_addr, sdram_dq_oe, sdram_cke};
  assign grants_v = {29'b0, aref_en, wr_en, rd_en};
  assign dq_v     = {16'b0, sdram_dq_out};

  function automatic logic [31:0] pins_of(input logic [3:0] c, input logic [1:0] b,
                                          input logic [12:0] a, input logic oe);
    return {11'b0, c, b, a, oe, 1'b1};
  endfunction

  localparam logic [31:0] NOP_PINS = {11'b0, 4'b0111, 2'b11, 13'h1fff, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model: who owns the bus, and what the pins carry ----------------
  localparam int OInit = 0, OIdle = 1, OAref = 2, OWr = 3, ORd = 4;
  int          m_owner = OInit;
  logic [3:0]  m_cmd = 4'b0111;
  logic [1:0]  m_ba = 2'b11;
  logic [12:0] m_addr = 13'h1fff;
  logic [15:0] m_dq = 16'h0;
  logic        m_oe = 1'b0;
  logic        m_prefer_wr;

`ifdef SDRAM_ARB_RR_EN
  logic m_last_wr = 1'b0;
  assign m_prefer_wr = ~m_last_wr;
  always @(posedge arb_clk) begin
    if (arb_rst) m_last_wr <= 1'b0;
    else if (m_owner == OIdle && !aref_req && (wr_req || rd_req))
      m_last_wr <= wr_req && (!rd_req || m_prefer_wr);
  end
`else
  assign m_prefer_wr = 1'b1;
`endif

  always @(posedge arb_clk) begin
    if (arb_rst) begin
      m_owner <= OInit;
      {m_cmd, m_ba, m_addr} <= {4'b0111, 2'b11, 13'h1fff};
      m_dq <= 16'h0;
      m_oe <= 1'b0;
    end else begin
      // pins next cycle = whatever the current owner is driving now
      if (m_owner == OInit)      {m_cmd, m_ba, m_addr} <= {init_cmd, init_bank, init_addr};
      else if (m_owner == OAref) {m_cmd, m_ba, m_addr} <= {aref_cmd, aref_bank, aref_addr};
      else if (m_owner == OWr)   {m_cmd, m_ba, m_addr} <= {wr_cmd, wr_bank, wr_addr};
      else if (m_owner == ORd)   {m_cmd, m_ba, m_addr} <= {rd_cmd, rd_bank, rd_addr};
      else                       {m_cmd, m_ba, m_addr} <= {4'b0111, 2'b11, 13'h1fff};
      m_oe <= (m_owner == OWr) && wr_sdram_en;
      m_dq <= ((m_owner == OWr) && wr_sdram_en) ? wr_sdram_data : 16'h0;
      // ownership changes
      if (m_owner == OInit && init_end) m_owner <= OIdle;
      else if (m_owner == OIdle) begin
        if (aref_req) m_owner <= OAref;
        else if (wr_req && (!rd_req || m_prefer_wr)) m_owner <= OWr;
        else if (rd_req) m_owner <= ORd;
      end
      else if (m_owner == OAref && aref_end) m_owner <= OIdle;
      else if (m_owner == OWr && wr_end) m_owner <= OIdle;
      else if (m_owner == ORd && rd_end) m_owner <= OIdle;
    end
  end

  // Cycle compare on the falling edge, away from the active edge
  always @(negedge arb_clk) begin
    if (check_en) begin
      chk("grants", grants_v,
          {29'b0, (m_owner == OAref) && !arb_rst, (m_owner == OWr) && !arb_rst,
           (m_owner == ORd) && !arb_rst});
      chk("pins", pins_v, pins_of(m_cmd, m_ba, m_addr, m_oe));
      chk("dq", dq_v, {16'b0, m_dq});
    end
  end

  task automatic step();
    @(posedge arb_clk);
    #1;
  endtask

  task automatic wait_grant(output logic [2:0] g);
    g = 3'b000;
    for (int i = 0; i < 10 && g == 3'b000; i++) begin
      step();
      g = {aref_en, wr_en, rd_en};
    end
    if (g == 3'b000) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout got=000 exp=nonzero t=%0t", $time);
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [2:0] g;
  logic [2:0] alt_exp [4];
  logic [2:0] pri_exp;

  initial begin
    step();
    step();
    check_en = 1'b1;
    chk("rst_pins", pins_v, NOP_PINS);
    chk("rst_grants", grants_v, 32'h0);
    chk("rst_dq", dq_v, 32'h0);

    // Hold in INIT for 20 cycles with the init channel driving
    arb_rst   = 1'b0;
    init_cmd  = 4'b0001;
    init_bank = 2'b00;
    init_addr = 13'h0400;
    repeat (20) step();
    chk("init_pins", pins_v, pins_of(4'b0001, 2'b00, 13'h0400, 1'b0));
    chk("init_grants", grants_v, 32'h0);

    init_end = 1'b1;
    step();
    chk("arbit_grants", grants_v, 32'h0);
    step();
    chk("arbit_nop", pins_v, NOP_PINS);

    // Write grant and one-cycle pin latency
    wr_cmd  = 4'b0011;
    wr_bank = 2'b10;
    wr_addr = 13'h0123;
    wr_req  = 1'b1;
    step();
    chk("wr_grant", grants_v, 32'h2);
    wr_req = 1'b0;
    step();
    chk("wr_act_pins", pins_v, pins_of(4'b0011, 2'b10, 13'h0123, 1'b0));

    // Write data alignment, foreign end ignored
    wr_cmd        = 4'b0100;
    wr_sdram_en   = 1'b1;
    wr_sdram_data = 16'hA5A5;
    rd_end        = 1'b1;
    step();
    chk("wr_dq", dq_v, 32'h0000A5A5);
    chk("wr_oe", {31'b0, sdram_dq_oe}, 32'h1);
    chk("rd_end_ignored", grants_v, 32'h2);
    rd_end      = 1'b0;
    wr_sdram_en = 1'b0;
    wr_end      = 1'b1;
    step();
    chk("wr_released", grants_v, 32'h0);
    wr_end = 1'b0;

    // All three requests together: refresh first
    aref_req = 1'b1;
    wr_req   = 1'b1;
    rd_req   = 1'b1;
    step();
    chk("aref_first", grants_v, 32'h4);
    aref_req = 1'b0;
    step();
    step();
    aref_end = 1'b1;
    step();
    chk("aref_gap", grants_v, 32'h0);
    aref_end = 1'b0;
    step();
`ifdef SDRAM_ARB_RR_EN
    pri_exp = 3'b001;
`else
    pri_exp = 3'b010;
`endif
    chk("after_aref", grants_v, {29'b0, pri_exp});
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
    wr_end = 1'b1;
    rd_end = 1'b1;
    step();
    wr_end = 1'b0;
    rd_end = 1'b0;
    step();

    // Reset in the middle of a write
    wr_req = 1'b1;
    step();
    wr_req        = 1'b0;
    wr_sdram_en   = 1'b1;
    wr_sdram_data = 16'h5A5A;
    step();
    init_end = 1'b0;
    arb_rst  = 1'b1;
    #1;
    chk("rst_drops_wr_en", grants_v, 32'h0);
    step();
    chk("rst_mid_pins", pins_v, NOP_PINS);
    chk("rst_mid_dq", dq_v, 32'h0);
    arb_rst     = 1'b0;
    wr_sdram_en = 1'b0;
    init_cmd    = 4'b0010;
    step();
    chk("reinit_pins", pins_v, pins_of(4'b0010, 2'b00, 13'h0400, 1'b0));

    // Write and read both held: tie-break sequence
    init_end = 1'b1;
    step();
    wr_req = 1'b1;
    rd_req = 1'b1;
`ifdef SDRAM_ARB_RR_EN
    alt_exp = '{3'b010, 3'b001, 3'b010, 3'b001};
`else
    alt_exp = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      chk($sformatf("tie_grant%0d", k), {29'b0, g}, {29'b0, alt_exp[k]});
      step();
      if (g[1]) wr_end = 1'b1;
      else rd_end = 1'b1;
      step();
      wr_end = 1'b0;
      rd_end = 1'b0;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
    step();
    step();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
